// File: rtl/ks_pkg.sv
// Shared definitions for the Kogge-Stone sum accumulator: FSM states,
// upstream result width and default sizing.
package ks_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int KS_RES_W     = 5;
    localparam int KS_BEATS_DEF = 16;
    localparam int KS_ACC_W_DEF = 8;

endpackage

// File: rtl/ks_acc_add.sv
// ACC_W-bit accumulate step with overflow detect; define KS_ACCUM_SATURATE_EN
// to clamp at all-ones on overflow, otherwise the result wraps.
module ks_acc_add
    import ks_pkg::*;
#(
    parameter int ACC_W = KS_ACC_W_DEF
) (
    input  logic [ACC_W-1:0]    acc,
    input  logic [KS_RES_W-1:0] addend,
    output logic [ACC_W-1:0]    result,
    output logic                ovf
);

    logic [ACC_W:0] sum;

    assign sum = {1'b0, acc} + {{(ACC_W + 1 - KS_RES_W){1'b0}}, addend};
    assign ovf = sum[ACC_W];

`ifdef KS_ACCUM_SATURATE_EN
    assign result = ovf ? '1 : sum[ACC_W-1:0];
`else
    assign result = sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/ks_sum_accumulator.sv
// Sums BEATS adder results per frame and presents the total with a sticky
// overflow flag over a valid/ready handshake.
module ks_sum_accumulator
    import ks_pkg::*;
#(
    parameter int BEATS = KS_BEATS_DEF,
    parameter int ACC_W = KS_ACC_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KS_RES_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic                out_ovf,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int CNT_W = $clog2(BEATS + 1);

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_sum;
    logic [CNT_W-1:0] count;
    logic             ovf, add_ovf;
    logic             beat, last_beat, handshake;

    ks_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc    (acc),
        .addend (in_data),
        .result (acc_sum),
        .ovf    (add_ovf)
    );

    assign in_ready  = (state != HOLD);
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && (count == CNT_W'(BEATS - 1));
    assign handshake = (state == HOLD) && out_ready;

    assign out_data  = acc;
    assign out_ovf   = ovf;
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat) state_next = last_beat ? HOLD : ACCUM;
            ACCUM:   if (last_beat) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake clears the frame so the next beat can only land a cycle later.
    always_ff @(posedge clk) begin
        if (rst || handshake) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (beat) begin
            acc   <= acc_sum;
            count <= count + CNT_W'(1);
            ovf   <= ovf | add_ovf;
        end
    end

endmodule
